// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared types and constants for the data-memory arbiter
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic RQ0 = 1'b0;
    localparam logic RQ1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// rr_pick2 : 2-way round-robin picker; a tie goes to the requester not in last_i
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    assign gnt_o[0] = req_i[0] & (~req_i[1] |  last_i);
    assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : round-robin arbiter with lock/watchdog for a shared data memory
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_err
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rvalid_q;
    logic             rd_tag_q;
    logic [1:0]       pick;
    logic [1:0]       gnt;
    logic             sel_we;
    logic             own_lock;

    rr_pick2 u_pick (
        .req_i  ({m1_req, m0_req}),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Grants are gated by rst_n so nothing reaches the memory while in reset.
    always_comb begin
        gnt = 2'b00;
        case (state_q)
            ST_IDLE:  gnt = pick;
            ST_LOCK0: gnt[0] = m0_req;
            ST_LOCK1: gnt[1] = m1_req;
            default:  gnt = 2'b00;
        endcase
        if (!rst_n) begin
            gnt = 2'b00;
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign sel_we    = gnt[1] ? m1_we    : m0_we;
    assign mem_addr  = gnt[1] ? m1_addr  : m0_addr;
    assign mem_wdata = gnt[1] ? m1_wdata : m0_wdata;
    assign mem_we    = (|gnt) &  sel_we;
    assign mem_re    = (|gnt) & ~sel_we;
    assign rdata     = mem_rdata;
    assign m0_rvalid = rvalid_q & (rd_tag_q == RQ0);
    assign m1_rvalid = rvalid_q & (rd_tag_q == RQ1);

    assign own_lock = (state_q == ST_LOCK1) ? m1_lock : m0_lock;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        lock_err = 1'b0;
        if (|gnt) begin
            last_d = gnt[1];
        end
        case (state_q)
            ST_IDLE: begin
                if (gnt[0] && m0_lock) begin
                    state_d = ST_LOCK0;
                    cnt_d   = CNT_W'(1);
                end else if (gnt[1] && m1_lock) begin
                    state_d = ST_LOCK1;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (!own_lock) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_MAX)) begin
                    // Forced release hands the next tie to the other requester.
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    lock_err = 1'b1;
                    last_d   = (state_q == ST_LOCK1) ? RQ1 : RQ0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_q   <= RQ1;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rd_tag_q <= RQ0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rvalid_q <= mem_re;
            if (mem_re) begin
                rd_tag_q <= gnt[1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : self-checking bench with a read-return scoreboard
// Rev 1.0         : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int LOCK_MAX = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DATA_W-1:0] rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we, mem_re, lock_err;
    logic [DATA_W-1:0] mem_rdata = '0;

    typedef struct {
        logic              tag;
        logic [DATA_W-1:0] data;
        int                due;
    } sb_t;

    sb_t               sb_q[$];
    logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    int                n_chk = 0;
    int                n_err = 0;
    int                cyc_n = 0;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .lock_err  (lock_err)
    );

    always #5 clk = ~clk;

    // Single-ported memory with registered read data
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (m0_rvalid || m1_rvalid) begin
            if (sb_q.size() == 0 || sb_q[0].due != cyc_n) begin
                check("rv_spurious", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("rv_tag", {30'd0, m1_rvalid, m0_rvalid}, e.tag ? 32'd2 : 32'd1);
                check("rdata", {24'd0, rdata}, {24'd0, e.data});
            end
        end else if (sb_q.size() != 0 && sb_q[0].due == cyc_n) begin
            e = sb_q.pop_front();
            check("rv_missing", {30'd0, m1_rvalid, m0_rvalid}, e.tag ? 32'd2 : 32'd1);
        end
    end

    // One cycle with the current inputs: check grants, command and lock_err
    task automatic cyc(input logic g0, input logic g1, input logic err);
        logic              s;
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        @(negedge clk);
        check("m0_gnt", {31'd0, m0_gnt}, {31'd0, g0});
        check("m1_gnt", {31'd0, m1_gnt}, {31'd0, g1});
        check("lock_err", {31'd0, lock_err}, {31'd0, err});
        check("we_re_excl", {31'd0, mem_we & mem_re}, 32'd0);
        if (g0 || g1) begin
            s  = g1;
            we = s ? m1_we : m0_we;
            a  = s ? m1_addr : m0_addr;
            d  = s ? m1_wdata : m0_wdata;
            check("mem_addr", {24'd0, mem_addr}, {24'd0, a});
            check("mem_we", {31'd0, mem_we}, {31'd0, we});
            check("mem_re", {31'd0, mem_re}, {31'd0, ~we});
            if (we) begin
                check("mem_wdata", {24'd0, mem_wdata}, {24'd0, d});
                ref_mem[a] = d;
            end else begin
                sb_q.push_back('{tag: s, data: ref_mem[a], due: cyc_n + 1});
            end
        end else begin
            check("mem_idle", {30'd0, mem_we, mem_re}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[8'h20]     = 8'h07;
        ref_mem[8'h20] = 8'h07;

        // Requests during reset must not produce grants or memory strobes
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("reset_mem", {30'd0, mem_we, mem_re}, 32'd0);
        check("reset_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check("reset_lock_err", {31'd0, lock_err}, 32'd0);
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then read-back by the other requester
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 8'hA5;
        cyc(1'b1, 1'b0, 1'b0);
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h10;
        cyc(1'b0, 1'b1, 1'b0);
        m1_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Continuous contention alternates, starting with requester 0
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 8'h30; m1_addr = 8'h40;
        for (int i = 0; i < 6; i++) begin
            cyc((i % 2) == 0, (i % 2) == 1, 1'b0);
            if ((i % 2) == 0) m0_addr = m0_addr + 8'd1;
            else              m1_addr = m1_addr + 8'd1;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Locked read-modify-write by requester 0 blocks requester 1
        m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 8'h20;
        m1_req = 1'b1; m1_addr = 8'h20;
        cyc(1'b1, 1'b0, 1'b0);
        m0_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b0; m0_wdata = 8'h08;
        cyc(1'b1, 1'b0, 1'b0);
        m0_req = 1'b0; m0_we = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        m1_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Requester 1 holds the lock until the watchdog fires
        m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 8'h50;
        cyc(1'b0, 1'b1, 1'b0);
        m0_req = 1'b1; m0_addr = 8'h60;
        for (int k = 1; k <= LOCK_MAX; k++) begin
            cyc(1'b0, 1'b1, k == LOCK_MAX);
        end
        cyc(1'b1, 1'b0, 1'b0);
        m0_req = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        m1_lock = 1'b0; m1_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Lock held just short of the limit, then dropped; counter must restart
        m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 8'h70;
        cyc(1'b1, 1'b0, 1'b0);
        m0_req = 1'b0;
        for (int k = 1; k < LOCK_MAX; k++) cyc(1'b0, 1'b0, 1'b0);
        m0_lock = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        m1_req = 1'b1; m1_addr = 8'h71;
        cyc(1'b0, 1'b1, 1'b0);
        m1_req = 1'b0;
        m0_req = 1'b1; m0_lock = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        m0_req = 1'b0;
        for (int k = 1; k < LOCK_MAX; k++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        m0_lock = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Reset asserted during a granted read drops it and restores tie order
        m0_req = 1'b1; m0_addr = 8'h11;
        @(negedge clk);
        check("pre_rst_gnt", {31'd0, m0_gnt}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m1_req = 1'b1; m1_addr = 8'h12;
        cyc(1'b1, 1'b0, 1'b0);
        m0_req = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        m1_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port round-robin arbiter that shares the single-ported 8-bit data memory between requester 0 (CPU load/store stage) and requester 1 (debug/DMA loader). It issues at most one access per cycle. It returns read data with one-cycle latency, tagged to the issuing requester. It also supports a lock for atomic read-modify-write sequences, with a timeout watchdog on the lock.

Parameters:
ADDR_W, 8, address width (memory depth 2**ADDR_W)
DATA_W, 8, data width
LOCK_MAX, 16, max consecutive cycles one requester may hold the lock before forced release (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  requester 0 access request, held until granted
m0_we  in  1  1=write, 0=read
m0_lock  in  1  request/hold exclusive ownership
m0_addr  in  ADDR_W  address
m0_wdata  in  DATA_W  write data
m0_gnt  out  1  access accepted this cycle
m0_rvalid  out  1  rdata valid for requester 0
m1_req, m1_we, m1_lock, m1_addr, m1_wdata  in  as m0  requester 1
m1_gnt, m1_rvalid  out  1  as m0
rdata  out  DATA_W  read data (pass-through of mem_rdata)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_re  out  1  memory read enable
mem_rdata  in  DATA_W  memory data_out (registered inside memory)
lock_err  out  1  one-cycle pulse on lock timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_grant=1 (requester 0 wins first tie), lock_cnt=0, rd_tag=0, m0_rvalid=m1_rvalid=0, lock_err=0. m*_gnt, mem_we and mem_re are forced 0 while rst_n=0.
- Grant (combinational from state and requests):
  - IDLE, one req: grant it.
  - IDLE, both req: grant the requester not equal to last_grant.
  - LOCK_k: only k can be granted; the other requester's req is ignored (held pending).
- Command: mem_addr/mem_wdata are muxed from the granted requester. mem_we=gnt&we, mem_re=gnt&~we. Never both high. With no grant, mem_addr/mem_wdata hold the requester-0 values and we=re=0.
- Read return: on a granted read, rd_tag<=winner and m{winner}_rvalid<=1 at the next edge, for one cycle. rdata=mem_rdata. Latency is 1 cycle from gnt to rvalid. Back-to-back reads from alternating requesters give rvalid on consecutive cycles, each correctly tagged.
- last_grant updates to the winner at every granted edge.
- FSM:
  - IDLE->LOCK_k when k is granted with m{k}_lock=1. lock_cnt<=1.
  - LOCK_k->IDLE when m{k}_lock=0 sampled at the edge, whether or not k is requesting. A final granted access with lock=0 executes, then releases.
  - In LOCK_k, lock_cnt increments each cycle. When lock_cnt==LOCK_MAX with lock still high: forced ->IDLE, lock_err=1 for one cycle, and last_grant=k so the other requester wins the next tie. A requester that keeps lock high re-acquires only after losing or winning normal arbitration.
- Simultaneous lock request by both in IDLE: normal round-robin decides. The loser waits.
- A write is visible to a read granted on any later cycle (memory property).
- Reset mid-read: the pending rvalid is dropped and the requester must reissue.

Decomposition:
- Shared package dmem_pkg: ADDR_W/DATA_W defaults, state encoding (ST_IDLE, ST_LOCK0, ST_LOCK1), requester ID constants (RQ0=0, RQ1=1).
- Optional sub-module rr_pick2: 2-way round-robin picker (req[1:0], last → gnt[1:0]).
- Memory instance stays outside. A top-level wrapper connects mem_* to data_memory.

Test Plan:
- Reset release, m0 write addr 0x10 data 0xA5, next cycle m1 read 0x10 → m0_gnt at cycle 1, mem_we=1. m1_gnt next cycle. m1_rvalid one cycle later with rdata=0xA5, and m0_rvalid stays 0.
- Both req continuously, reads of distinct addresses → grants alternate 0,1,0,1 starting with 0. rvalid tags alternate. mem_re never overlaps mem_we.
- m0 lock read 0x20 (mem 0x07), m1 req held, m0 write 0x08 with lock=0 → m1_gnt low until the cycle after m0's unlocked write. m1 read 0x20 returns 0x08.
- m1 holds lock and req high, LOCK_MAX=16, m0 requesting → lock_err pulses at lock cycle 16. m0_gnt on the next cycle.
- rst_n pulled low during a granted read → m*_rvalid=0 and gnt=0 immediately. After release, the first tie goes to m0.
- m0 req with lock only, never released, m1 idle → no lock_err before LOCK_MAX. FSM returns to IDLE on lock drop, with lock_cnt cleared.
